// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: function codes, forwarding selects and
// the multiplier sequencer states.
package exec_pkg;

    typedef enum logic [4:0] {
        FN_ADD = 5'd0,
        FN_SUB = 5'd1,
        FN_AND = 5'd2,
        FN_OR  = 5'd3,
        FN_XOR = 5'd4,
        FN_SLL = 5'd5,
        FN_SRL = 5'd6,
        FN_SRA = 5'd7,
        FN_SLT = 5'd8,
        FN_MUL = 5'd9
    } func_e;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_WB    = 2'd2;
    localparam logic [1:0] FWD_ZERO  = 2'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the low DATA_W bits of the product.
// One partial-product step per cycle; the last step is summed combinationally into product.
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_e            stateReg;
    logic [CNT_W-1:0]  countReg;
    logic [DATA_W-1:0] accReg;
    logic [DATA_W-1:0] mcandReg;
    logic [DATA_W-1:0] mplierReg;

    assign product = accReg + (mplierReg[0] ? mcandReg : '0);
    assign busy    = (stateReg == MUL_BUSY);
    assign done    = busy && (countReg == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            countReg  <= '0;
            accReg    <= '0;
            mcandReg  <= '0;
            mplierReg <= '0;
        end else if (abort) begin
            stateReg <= IDLE;
            countReg <= '0;
        end else if (!hold) begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        stateReg  <= MUL_BUSY;
                        countReg  <= '0;
                        accReg    <= '0;
                        mcandReg  <= multiplicand;
                        mplierReg <= multiplier;
                    end
                end
                MUL_BUSY: begin
                    if (countReg == LAST_STEP) begin
                        stateReg <= IDLE;
                        countReg <= '0;
                    end else begin
                        accReg    <= product;
                        mcandReg  <= mcandReg << 1;
                        mplierReg <= mplierReg >> 1;
                        countReg  <= countReg + CNT_W'(1);
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage_pipe.sv
// Execute stage with forwarding muxes, ALU and registered EX/MEM boundary.
// Define EXEC_MUL_EN to build the multi-cycle multiplier (otherwise code 9 is illegal).
module execute_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FUNC_W     = 5,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [FUNC_W-1:0]     in_func,
    input  logic                  in_alu_src,
    input  logic [1:0]            in_forward_a,
    input  logic [1:0]            in_forward_b,
    input  logic [DATA_W-1:0]     in_reg_a,
    input  logic [DATA_W-1:0]     in_reg_b,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [DATA_W-1:0]     in_wb_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_up,
    output logic                  ex_mem_valid,
    output logic [DATA_W-1:0]     ex_mem_result,
    output logic [DATA_W-1:0]     ex_mem_store_data,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  ex_mem_reg_write,
    output logic                  ex_mem_mem_read,
    output logic                  ex_mem_mem_write,
    output logic                  ex_mem_zero,
    output logic                  ex_mem_carry,
    output logic                  ex_mem_overflow,
    output logic                  ex_mem_negative,
    output logic                  ex_mem_illegal
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]  opA, fwdB, opB, aluResult;
    logic [DATA_W:0]    sum;
    logic [SHAMT_W-1:0] shamt;
    logic               aluCarry, aluOverflow, aluIllegal, issueAlu;

    always_comb begin
        case (in_forward_a)
            FWD_REG:   opA = in_reg_a;
            FWD_EXMEM: opA = ex_mem_result;
            FWD_WB:    opA = in_wb_data;
            default:   opA = '0;
        endcase
        case (in_forward_b)
            FWD_REG:   fwdB = in_reg_b;
            FWD_EXMEM: fwdB = ex_mem_result;
            FWD_WB:    fwdB = in_wb_data;
            default:   fwdB = '0;
        endcase
        opB   = in_alu_src ? in_imm : fwdB;
        shamt = opB[SHAMT_W-1:0];
    end

    always_comb begin
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        aluIllegal  = 1'b0;
        sum         = '0;
        case (in_func)
            FUNC_W'(FN_ADD): begin
                sum         = {1'b0, opA} + {1'b0, opB};
                aluResult   = sum[DATA_W-1:0];
                aluCarry    = sum[DATA_W];
                aluOverflow = (opA[DATA_W-1] == opB[DATA_W-1]) && (aluResult[DATA_W-1] != opA[DATA_W-1]);
            end
            FUNC_W'(FN_SUB): begin
                sum         = {1'b0, opA} + {1'b0, ~opB} + {{DATA_W{1'b0}}, 1'b1};
                aluResult   = sum[DATA_W-1:0];
                aluCarry    = sum[DATA_W];
                aluOverflow = (opA[DATA_W-1] != opB[DATA_W-1]) && (aluResult[DATA_W-1] != opA[DATA_W-1]);
            end
            FUNC_W'(FN_AND): aluResult = opA & opB;
            FUNC_W'(FN_OR):  aluResult = opA | opB;
            FUNC_W'(FN_XOR): aluResult = opA ^ opB;
            FUNC_W'(FN_SLL): aluResult = opA << shamt;
            FUNC_W'(FN_SRL): aluResult = opA >> shamt;
            FUNC_W'(FN_SRA): aluResult = $signed(opA) >>> shamt;
            FUNC_W'(FN_SLT): aluResult = {{(DATA_W-1){1'b0}}, $signed(opA) < $signed(opB)};
            default:         aluIllegal = 1'b1;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic                  isMul, acceptMul, mulBusy, mulDone;
    logic [DATA_W-1:0]     mulProduct, mulStoreReg;
    logic [REG_ADDR_W-1:0] mulRdReg;
    logic                  mulRegWriteReg, mulMemReadReg, mulMemWriteReg;

    assign isMul     = (in_func == FUNC_W'(FN_MUL));
    assign acceptMul = in_valid && isMul && !mulBusy && !hold && !flush;
    assign issueAlu  = in_valid && !isMul && !mulBusy;
    assign stall_up  = !flush && (hold || acceptMul || (mulBusy && !mulDone));

    seq_multiplier #(.DATA_W(DATA_W)) uMul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (acceptMul),
        .hold         (hold),
        .abort        (flush),
        .multiplicand (opA),
        .multiplier   (opB),
        .busy         (mulBusy),
        .done         (mulDone),
        .product      (mulProduct)
    );

    // Fields that travel alongside the product until it is written to EX/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulStoreReg    <= '0;
            mulRdReg       <= '0;
            mulRegWriteReg <= 1'b0;
            mulMemReadReg  <= 1'b0;
            mulMemWriteReg <= 1'b0;
        end else if (acceptMul) begin
            mulStoreReg    <= fwdB;
            mulRdReg       <= in_rd;
            mulRegWriteReg <= in_reg_write;
            mulMemReadReg  <= in_mem_read;
            mulMemWriteReg <= in_mem_write;
        end
    end
`else
    assign issueAlu = in_valid;
    assign stall_up = hold;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_result     <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_zero       <= 1'b0;
            ex_mem_carry      <= 1'b0;
            ex_mem_overflow   <= 1'b0;
            ex_mem_negative   <= 1'b0;
            ex_mem_illegal    <= 1'b0;
        end else if (flush) begin
            ex_mem_valid     <= 1'b0;
            ex_mem_reg_write <= 1'b0;
            ex_mem_mem_read  <= 1'b0;
            ex_mem_mem_write <= 1'b0;
            ex_mem_illegal   <= 1'b0;
        end else if (!hold) begin
            if (issueAlu) begin
                ex_mem_valid      <= 1'b1;
                ex_mem_result     <= aluResult;
                ex_mem_store_data <= fwdB;
                ex_mem_rd         <= in_rd;
                ex_mem_reg_write  <= in_reg_write;
                ex_mem_mem_read   <= in_mem_read;
                ex_mem_mem_write  <= in_mem_write;
                ex_mem_zero       <= (aluResult == '0);
                ex_mem_carry      <= aluCarry;
                ex_mem_overflow   <= aluOverflow;
                ex_mem_negative   <= aluResult[DATA_W-1];
                ex_mem_illegal    <= aluIllegal;
`ifdef EXEC_MUL_EN
            end else if (mulDone) begin
                ex_mem_valid      <= 1'b1;
                ex_mem_result     <= mulProduct;
                ex_mem_store_data <= mulStoreReg;
                ex_mem_rd         <= mulRdReg;
                ex_mem_reg_write  <= mulRegWriteReg;
                ex_mem_mem_read   <= mulMemReadReg;
                ex_mem_mem_write  <= mulMemWriteReg;
                ex_mem_zero       <= (mulProduct == '0);
                ex_mem_carry      <= 1'b0;
                ex_mem_overflow   <= 1'b0;
                ex_mem_negative   <= mulProduct[DATA_W-1];
                ex_mem_illegal    <= 1'b0;
`endif
            end else begin
                ex_mem_valid     <= 1'b0;
                ex_mem_reg_write <= 1'b0;
                ex_mem_mem_read  <= 1'b0;
                ex_mem_mem_write <= 1'b0;
                ex_mem_illegal   <= 1'b0;
            end
        end
    end

endmodule
